// File: rtl/lane_pipe_skid_reg_if.sv
// lane_pipe_skid_reg_if: valid/ready lane-vector handshake between upstream, pipe and downstream
interface lane_pipe_skid_reg_if #(
    parameter int LANES  = 16,
    parameter int DATA_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES-1:0]        in_lane_en;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES-1:0]        out_lane_en;
    logic [LANES*DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_lane_en, in_data, out_ready,
        output in_ready, out_valid, out_lane_en, out_data
    );
    modport master (
        output in_valid, in_lane_en, in_data, out_ready,
        input  in_ready, out_valid, out_lane_en, out_data
    );
endinterface

// File: rtl/lane_pipe_skid_reg.sv
// lane_pipe_skid_reg: multi-lane pipeline of 2-entry skid stages with per-lane hold of the last accepted value
module lane_pipe_skid_reg #(
    parameter int LANES  = 16,
    parameter int DATA_W = 8,
    parameter int STAGES = 2,
    localparam int OCC_W = $clog2(2*STAGES+1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    lane_pipe_skid_reg_if.slave bus,
    output logic [OCC_W-1:0]   occupancy
);
    localparam int DW = LANES*DATA_W;
    localparam int BW = DW + LANES;

    logic [BW-1:0]     m_q [STAGES];
    logic [BW-1:0]     s_q [STAGES];
    logic [BW-1:0]     up_d [STAGES];
    logic [STAGES-1:0] vm, vs, up_v, dn_r;
    logic [DW-1:0]     shadow, merged;
    logic              in_xfer, out_xfer;

    always_comb begin
        for (int l = 0; l < LANES; l++)
            merged[l*DATA_W +: DATA_W] = bus.in_lane_en[l] ? bus.in_data[l*DATA_W +: DATA_W] : shadow[l*DATA_W +: DATA_W];
    end

    // stage k is fed by stage k-1's main reg and drained into stage k+1 (or the output)
    assign up_v = STAGES'({vm, bus.in_valid});
    assign dn_r = STAGES'({bus.out_ready, ~vs} >> 1);

    always_comb begin
        up_d[0] = {bus.in_lane_en, merged};
        for (int k = 1; k < STAGES; k++)
            up_d[k] = m_q[k-1];
    end

    assign in_xfer  = bus.in_valid & ~vs[0];
    assign out_xfer = vm[STAGES-1] & bus.out_ready;

    assign bus.in_ready  = ~vs[0];
    assign bus.out_valid = vm[STAGES-1];
    assign {bus.out_lane_en, bus.out_data} = m_q[STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vm        <= '0;
            vs        <= '0;
            shadow    <= '0;
            occupancy <= '0;
            for (int k = 0; k < STAGES; k++) begin
                m_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (flush) begin
            vm        <= '0;
            vs        <= '0;
            shadow    <= '0;
            occupancy <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (vs[k]) begin
                    if (dn_r[k]) begin
                        m_q[k] <= s_q[k];
                        vs[k]  <= 1'b0;
                    end
                end else if (up_v[k]) begin
                    if (vm[k] && !dn_r[k]) begin
                        s_q[k] <= up_d[k];
                        vs[k]  <= 1'b1;
                    end else begin
                        m_q[k] <= up_d[k];
                        vm[k]  <= 1'b1;
                    end
                end else if (dn_r[k]) begin
                    vm[k] <= 1'b0;
                end
            end
            if (in_xfer)
                shadow <= merged;
            occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end
endmodule
